// File: rtl/multi_mode_game_counter.sv
// -----------------------------------------------------------------------------
// multi_mode_game_counter
//
// Purpose:
//   An up/down counter with a programmable step that also keeps game scores.
//   A win event occurs when an update lands on MAX, and a lose event occurs
//   when an update lands on 0. Each event bumps its own score counter.
//   When either score reaches SMAX, the game ends: gameover is raised and the
//   count, the scores and who are frozen until restart or rst.
//
// Configuration:
//   MULTI_MODE_GAME_COUNTER_SATURATE_EN
//     Defined   : updates clamp at MAX / 0. Landing there by clamping
//                 still raises the matching event.
//     Undefined : updates wrap modulo 2^WIDTH.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   en        in   count-update enable
//   mode[1:0] in   00 up 1, 01 up step, 10 down 1, 11 down step
//   step      in   step magnitude (used in modes 01/11)
//   init      in   load init_val into count
//   init_val  in   load value
//   restart   in   clear game state and load init_val
//   count     out  registered count
//   winner    out  one-cycle win pulse
//   loser     out  one-cycle lose pulse
//   who[1:0]  out  00 none, 01 win side ended game, 10 lose side ended game
//   gameover  out  high while the game is over
// -----------------------------------------------------------------------------
module multi_mode_game_counter #(
  parameter int WIDTH       = 5,
  parameter int SCORE_WIDTH = 4,
  parameter int STEP_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic                  init,
  input  logic [WIDTH-1:0]      init_val,
  input  logic                  restart,
  output logic [WIDTH-1:0]      count,
  output logic                  winner,
  output logic                  loser,
  output logic [1:0]            who,
  output logic                  gameover
);

  // Arithmetic width wide enough for count + step without losing the carry.
  localparam int AW = ((WIDTH > STEP_WIDTH) ? WIDTH : STEP_WIDTH) + 1;

  localparam logic [WIDTH-1:0]       MAX      = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]       ZERO     = {WIDTH{1'b0}};
  localparam logic [SCORE_WIDTH-1:0] SMAX     = {SCORE_WIDTH{1'b1}};
  localparam logic [1:0]             WHO_NONE = 2'b00;
  localparam logic [1:0]             WHO_WIN  = 2'b01;
  localparam logic [1:0]             WHO_LOSE = 2'b10;
`ifdef MULTI_MODE_GAME_COUNTER_SATURATE_EN
  localparam logic [AW-1:0]          MAX_EXT  = {{(AW-WIDTH){1'b0}}, MAX};
`endif

  logic [WIDTH-1:0]       count_q, count_d;
  logic [SCORE_WIDTH-1:0] win_score_q, win_score_d;
  logic [SCORE_WIDTH-1:0] lose_score_q, lose_score_d;
  logic                   winner_q, winner_d;
  logic                   loser_q, loser_d;
  logic [1:0]             who_q, who_d;
  logic                   gameover_q, gameover_d;

  logic [AW-1:0]          delta_s;
  logic [AW-1:0]          cnt_ext_s;
  logic [AW-1:0]          up_sum_s;
  logic [AW-1:0]          dn_diff_s;
  logic [WIDTH-1:0]       upd_count_s;
  logic                   upd_win_s;
  logic                   upd_lose_s;

  // Candidate count after an enabled update, and the event it would raise.
  always_comb begin
    cnt_ext_s = {{(AW-WIDTH){1'b0}}, count_q};
    if (mode[0]) begin
      delta_s = {{(AW-STEP_WIDTH){1'b0}}, step};
    end else begin
      delta_s = {{(AW-1){1'b0}}, 1'b1};
    end
    up_sum_s  = cnt_ext_s + delta_s;
    dn_diff_s = cnt_ext_s - delta_s;
`ifdef MULTI_MODE_GAME_COUNTER_SATURATE_EN
    if (!mode[1]) begin
      upd_count_s = (up_sum_s >= MAX_EXT) ? MAX : WIDTH'(up_sum_s);
    end else begin
      upd_count_s = (delta_s >= cnt_ext_s) ? ZERO : WIDTH'(dn_diff_s);
    end
`else
    if (!mode[1]) begin
      upd_count_s = WIDTH'(up_sum_s);
    end else begin
      upd_count_s = WIDTH'(dn_diff_s);
    end
`endif
    // A zero step is a hold. It raises no event, even if count already sits on MAX or 0.
    upd_win_s  = (delta_s != {AW{1'b0}}) && (upd_count_s == MAX);
    upd_lose_s = (delta_s != {AW{1'b0}}) && (upd_count_s == ZERO);
  end

  // Next-state selection by priority: restart, frozen, init, update, hold.
  always_comb begin
    count_d      = count_q;
    win_score_d  = win_score_q;
    lose_score_d = lose_score_q;
    who_d        = who_q;
    gameover_d   = gameover_q;
    winner_d     = 1'b0;
    loser_d      = 1'b0;
    if (restart) begin
      count_d      = init_val;
      win_score_d  = {SCORE_WIDTH{1'b0}};
      lose_score_d = {SCORE_WIDTH{1'b0}};
      who_d        = WHO_NONE;
      gameover_d   = 1'b0;
    end else if (gameover_q) begin
      count_d = count_q;
    end else if (init) begin
      count_d = init_val;
    end else if (en) begin
      count_d      = upd_count_s;
      winner_d     = upd_win_s;
      loser_d      = upd_lose_s;
      win_score_d  = win_score_q + {{(SCORE_WIDTH-1){1'b0}}, upd_win_s};
      lose_score_d = lose_score_q + {{(SCORE_WIDTH-1){1'b0}}, upd_lose_s};
      // Only one event fires per update, so at most one score reaches SMAX here.
      if (win_score_d == SMAX) begin
        gameover_d = 1'b1;
        who_d      = WHO_WIN;
      end else if (lose_score_d == SMAX) begin
        gameover_d = 1'b1;
        who_d      = WHO_LOSE;
      end else begin
        gameover_d = 1'b0;
      end
    end else begin
      count_d = count_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= {WIDTH{1'b0}};
      win_score_q  <= {SCORE_WIDTH{1'b0}};
      lose_score_q <= {SCORE_WIDTH{1'b0}};
      winner_q     <= 1'b0;
      loser_q      <= 1'b0;
      who_q        <= WHO_NONE;
      gameover_q   <= 1'b0;
    end else begin
      count_q      <= count_d;
      win_score_q  <= win_score_d;
      lose_score_q <= lose_score_d;
      winner_q     <= winner_d;
      loser_q      <= loser_d;
      who_q        <= who_d;
      gameover_q   <= gameover_d;
    end
  end

  assign count    = count_q;
  assign winner   = winner_q;
  assign loser    = loser_q;
  assign who      = who_q;
  assign gameover = gameover_q;

endmodule

// File: tb/tb_multi_mode_game_counter.sv
module tb_multi_mode_game_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [2:0] step;
  logic       init;
  logic [4:0] init_val;
  logic       restart;
  logic [4:0] count;
  logic       winner;
  logic       loser;
  logic [1:0] who;
  logic       gameover;

  int n_cmp;
  int n_err;

  multi_mode_game_counter #(
    .WIDTH(5),
    .SCORE_WIDTH(4),
    .STEP_WIDTH(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .mode(mode),
    .step(step),
    .init(init),
    .init_val(init_val),
    .restart(restart),
    .count(count),
    .winner(winner),
    .loser(loser),
    .who(who),
    .gameover(gameover)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One rising edge. Outputs are then sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int c, input int w, input int l,
                           input int wh, input int go);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".winner"}, 32'(winner), 32'(w));
    check({tag, ".loser"}, 32'(loser), 32'(l));
    check({tag, ".who"}, 32'(who), 32'(wh));
    check({tag, ".gameover"}, 32'(gameover), 32'(go));
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    en       = 1'b1;
    mode     = 2'b00;
    step     = 3'd0;
    init     = 1'b0;
    init_val = 5'd0;
    restart  = 1'b0;
    tick();
    check_all("reset", 0, 0, 0, 0, 0);

    // Count up by 1 until the win score reaches 15 on update 479.
    rst = 1'b0;
    for (int k = 1; k <= 479; k++) begin
      tick();
      check("up.count", 32'(count), 32'(k % 32));
      check("up.winner", 32'(winner), 32'((k % 32) == 31));
      check("up.loser", 32'(loser), 32'((k % 32) == 0));
      check("up.gameover", 32'(gameover), 32'(k == 479));
    end
    check("up.who", 32'(who), 32'd1);

    // While the game is over, init and en are ignored.
    init     = 1'b1;
    init_val = 5'd3;
    tick();
    check_all("frozen", 31, 0, 0, 1, 1);
    tick();
    check_all("frozen2", 31, 0, 0, 1, 1);

    // restart wins over init and en.
    restart  = 1'b1;
    init_val = 5'd10;
    tick();
    check_all("restart", 10, 0, 0, 0, 0);
    restart = 1'b0;
    init    = 1'b0;
    tick();
    check_all("resume", 11, 0, 0, 0, 0);

    // Loading MAX with init gives no event, even with en high.
    init     = 1'b1;
    init_val = 5'd31;
    tick();
    check_all("init_max", 31, 0, 0, 0, 0);

    // Down by step 4 from 8.
    init_val = 5'd8;
    tick();
    check("init8.count", 32'(count), 32'd8);
    init = 1'b0;
    mode = 2'b11;
    step = 3'd4;
    tick();
    check_all("dn4_a", 4, 0, 0, 0, 0);
    tick();
    check_all("dn4_b", 0, 0, 1, 0, 0);
    step = 3'd0;
    tick();
    check_all("step0", 0, 0, 0, 0, 0);

    // Down by 1 from 0. Step is ignored in mode 10.
    mode = 2'b10;
    step = 3'd5;
    tick();
`ifdef MULTI_MODE_GAME_COUNTER_SATURATE_EN
    check_all("dn_from0", 0, 0, 1, 0, 0);
`else
    check_all("dn_from0", 31, 1, 0, 0, 0);
`endif

    // Up by step 7 from 30.
    init     = 1'b1;
    init_val = 5'd30;
    tick();
    check("init30.count", 32'(count), 32'd30);
    init = 1'b0;
    mode = 2'b01;
    step = 3'd7;
    tick();
`ifdef MULTI_MODE_GAME_COUNTER_SATURATE_EN
    check_all("up7", 31, 1, 0, 0, 0);
`else
    check_all("up7", 5, 0, 0, 0, 0);
`endif

    // Reach 17, then apply rst with en still high.
    init     = 1'b1;
    init_val = 5'd16;
    tick();
    init = 1'b0;
    mode = 2'b00;
    tick();
    check("pre_rst.count", 32'(count), 32'd17);
    rst = 1'b1;
    tick();
    check_all("mid_rst", 0, 0, 0, 0, 0);

    // The scores must be cleared: the game ends on update 479 again.
    rst = 1'b0;
    for (int k = 1; k <= 479; k++) begin
      tick();
      check("rerun.count", 32'(count), 32'(k % 32));
      check("rerun.gameover", 32'(gameover), 32'(k == 479));
    end
    check("rerun.who", 32'(who), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multi_mode_game_counter.md
MULTI_MODE_GAME_COUNTER -- requirements
Module: multi_mode_game_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, giving the count width; MAX = 2^WIDTH-1.
REQ-002 The block SHALL have parameter SCORE_WIDTH, default 4, giving the width of the internal win and lose score counters; SMAX = 2^SCORE_WIDTH-1.
REQ-003 The block SHALL have parameter STEP_WIDTH, default 3, giving the width of the programmable step.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 The block SHALL have port en, input, 1 bit, count-update enable.
REQ-007 The block SHALL have port mode, input, 2 bits: 00 up by 1, 01 up by step, 10 down by 1, 11 down by step.
REQ-008 The block SHALL have port step, input, STEP_WIDTH bits, the increment or decrement magnitude in modes 01 and 11; ignored in modes 00 and 10.
REQ-009 The block SHALL have port init, input, 1 bit, a load request for init_val.
REQ-010 The block SHALL have port init_val, input, WIDTH bits, the load value.
REQ-011 The block SHALL have port restart, input, 1 bit, which clears the game state.
REQ-012 The block SHALL have port count, output, WIDTH bits, the registered count.
REQ-013 The block SHALL have port winner, output, 1 bit, a one-cycle win-event pulse.
REQ-014 The block SHALL have port loser, output, 1 bit, a one-cycle lose-event pulse.
REQ-015 The block SHALL have port who, output, 2 bits: 00 none, 01 winner side ended the game, 10 loser side ended the game; 11 is never driven.
REQ-016 The block SHALL have port gameover, output, 1 bit, held high while the game is over.

Function
REQ-017 All outputs SHALL be registered, with a latency of one clock from the input sample to the output change.
REQ-018 Per-cycle priority SHALL be rst > restart > frozen-by-gameover > init > en-update > hold.
REQ-019 A count update SHALL set count to (count +/- delta) mod 2^WIDTH, where delta is 1 in modes 00/10 and step in modes 01/11.
REQ-020 A step of 0 in modes 01/11 SHALL hold count and generate no event.
REQ-021 winner SHALL pulse for exactly one cycle, aligned with count, when an update produces count==MAX; loser SHALL likewise pulse when an update produces count==0.
REQ-022 init loads, holds and reset SHALL never generate winner or loser events.
REQ-023 A step that skips over MAX or 0 without landing on it SHALL generate no event.
REQ-024 Each winner event SHALL increment the win score and each loser event SHALL increment the lose score, with the two counters independent.
REQ-025 gameover SHALL assert, with its final event pulse, in the cycle a score reaches SMAX; who SHALL be set to 01 if the win score reached SMAX and 10 if the lose score did.
REQ-026 While gameover is high, count, the scores and who SHALL be frozen, and init and en SHALL be ignored.
REQ-027 restart SHALL clear both scores, gameover, who, winner and loser, and SHALL load count with init_val; restart is honoured in any state.
REQ-028 init SHALL load count with init_val and leave the scores unchanged.

Reset
REQ-029 On rst, count, both scores, winner, loser, who and gameover SHALL all be 0 at the next edge.
REQ-030 rst asserted mid-game or during gameover SHALL take effect in the same way, with no event generated.

Configuration
REQ-031 When macro MULTI_MODE_GAME_COUNTER_SATURATE_EN is defined, updates SHALL clamp instead of wrap: up results at or above MAX become MAX, down results at or below 0 become 0, and a landing via clamp SHALL generate the corresponding event.
REQ-032 When MULTI_MODE_GAME_COUNTER_SATURATE_EN is undefined, arithmetic SHALL wrap modulo 2^WIDTH per REQ-019.

Verification (WIDTH=5, SCORE_WIDTH=4, STEP_WIDTH=3)
REQ-033 rst, mode=00, en=1 -> count 1,2,...,31 with winner on update 31, then count 0 with loser on update 32; gameover=1 and who=01 on update 479, after which count stays frozen at 31.
REQ-034 init_val=8 with init, then mode=11, step=4 -> count 4, then 0 with a single loser pulse; step=0 -> count held and no pulses.
REQ-035 init_val=30, mode=01, step=7 -> without the macro count=5 and no event; with the macro count=31 and winner=1.
REQ-036 During gameover, drive init and en -> no change; then restart with init_val=10 -> count=10, gameover=0 and who=00 on the next cycle, and counting resumes.
REQ-037 rst asserted mid-count at count=17 -> all outputs 0 on the next cycle with no pulse; the game restarts with both scores at 0.
